// File: rtl/mvu_pe_acc_pkg.sv
// Shared MVAU processing-element definitions: default geometry, counter
// sizing and lane extraction from the packed product bus.
package mvu_pe_acc_pkg;

  localparam int SIMD_DEF  = 2;
  localparam int TDSTI_DEF = 16;
  localparam int TDSTO_DEF = 24;
  localparam int SF_DEF    = 4;

  // Upper bounds for the generic lane helper; callers stay well below these.
  localparam int BUS_MAX  = 2048;
  localparam int LANE_MAX = 64;

  function automatic int sf_width(input int sf);
    int w;
    w = $clog2(sf);
    return (w < 1) ? 1 : w;
  endfunction

  // Returns lane k (w bits wide) of a packed bus, zero-extended to LANE_MAX.
  function automatic logic [LANE_MAX-1:0] get_lane(input logic [BUS_MAX-1:0] bus,
                                                   input int k,
                                                   input int w);
    logic [LANE_MAX-1:0] mask;
    mask = (w >= LANE_MAX) ? '1 : ((LANE_MAX'(1) << w) - LANE_MAX'(1));
    return LANE_MAX'(bus >> (k * w)) & mask;
  endfunction

endpackage

// File: rtl/mvu_pe_acc_if.sv
// Product-beat input stream and dot-product result stream of one PE.
interface mvu_pe_acc_if
  import mvu_pe_acc_pkg::*;
#(
  parameter int SIMD  = SIMD_DEF,
  parameter int TDstI = TDSTI_DEF,
  parameter int TDstO = TDSTO_DEF
) ();

  logic                  in_v;
  logic                  in_rdy;
  logic [SIMD*TDstI-1:0] in_prod;
  logic                  out_v;
  logic                  out_rdy;
  logic [TDstO-1:0]      out;

  modport slave (
    input  in_v,
    input  in_prod,
    input  out_rdy,
    output in_rdy,
    output out_v,
    output out
  );

  modport master (
    output in_v,
    output in_prod,
    output out_rdy,
    input  in_rdy,
    input  out_v,
    input  out
  );

endinterface

// File: rtl/mvu_pe_adders.sv
// Combinational adder tree: zero-extends each product lane and sums all
// lanes modulo 2^TDstO.
module mvu_pe_adders
  import mvu_pe_acc_pkg::*;
#(
  parameter int SIMD  = SIMD_DEF,
  parameter int TDstI = TDSTI_DEF,
  parameter int TDstO = TDSTO_DEF
) (
  input  logic [SIMD*TDstI-1:0] prod_i,
  output logic [TDstO-1:0]      sum_o
);

  logic [BUS_MAX-1:0]  bus_ext;
  logic [LANE_MAX-1:0] lane_w;
  logic [TDstO-1:0]    sum;

  assign bus_ext = BUS_MAX'(prod_i);

  always_comb begin
    sum    = '0;
    lane_w = '0;
    for (int k = 0; k < SIMD; k++) begin
      lane_w = get_lane(bus_ext, k, TDstI);
      sum    = sum + TDstO'(lane_w);
    end
  end

  assign sum_o = sum;

endmodule

// File: rtl/mvu_pe_acc.sv
// PE accumulator: reduces SIMD products per beat, accumulates SF beats and
// emits one dot-product result on a valid/ready stream.
module mvu_pe_acc
  import mvu_pe_acc_pkg::*;
#(
  parameter int SIMD  = SIMD_DEF,
  parameter int TDstI = TDSTI_DEF,
  parameter int TDstO = TDSTO_DEF,
  parameter int SF    = SF_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  mvu_pe_acc_if.slave s
);

  localparam int              SF_W    = sf_width(SF);
  localparam logic [SF_W-1:0] SF_LAST = SF_W'(SF - 1);

  logic [TDstO-1:0] sum;
  logic [TDstO-1:0] acc_q, acc_d, acc_next;
  logic [TDstO-1:0] out_q, out_d;
  logic             out_v_q, out_v_d;
  logic [SF_W-1:0]  sf_cnt_q, sf_cnt_d;
  logic             first_beat, last_beat;
  logic             in_rdy, acc_en;

  mvu_pe_adders #(
    .SIMD  (SIMD),
    .TDstI (TDstI),
    .TDstO (TDstO)
  ) u_adders (
    .prod_i (s.in_prod),
    .sum_o  (sum)
  );

  assign first_beat = (sf_cnt_q == '0);
  assign last_beat  = (sf_cnt_q == SF_LAST);

  // Only the fold-closing beat needs the output register, so only it stalls.
  assign in_rdy   = !(last_beat && out_v_q && !s.out_rdy);
  assign acc_en   = s.in_v && in_rdy;
  assign acc_next = first_beat ? sum : acc_q + sum;

  always_comb begin
    acc_d    = acc_q;
    sf_cnt_d = sf_cnt_q;
    out_d    = out_q;
    out_v_d  = out_v_q;
    if (out_v_q && s.out_rdy) begin
      out_v_d = 1'b0;
    end
    if (acc_en) begin
      acc_d    = acc_next;
      sf_cnt_d = last_beat ? '0 : sf_cnt_q + SF_W'(1);
      // A new result overrides a same-cycle transfer, keeping out_v high.
      if (last_beat) begin
        out_d   = acc_next;
        out_v_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q    <= '0;
      sf_cnt_q <= '0;
      out_q    <= '0;
      out_v_q  <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      sf_cnt_q <= sf_cnt_d;
      out_q    <= out_d;
      out_v_q  <= out_v_d;
    end
  end

  assign s.in_rdy = in_rdy;
  assign s.out_v  = out_v_q;
  assign s.out    = out_q;

endmodule
